// File: rtl/hazard_ctrl_pkg.sv
// Shared constants and types for the pipeline hazard/flush controller.
// Stall vector bits are ordered pc, if_id, id_ex, ex_mem, mem_wb, wb (1 = hold).
package hazard_ctrl_pkg;

    localparam int unsigned StallPc    = 0;
    localparam int unsigned StallIfId  = 1;
    localparam int unsigned StallIdEx  = 2;
    localparam int unsigned StallExMem = 3;
    localparam int unsigned StallMemWb = 4;

    localparam logic [5:0] StallNone = 6'b000000;
    localparam logic [5:0] StallIf   = 6'(1 << StallPc);
    localparam logic [5:0] StallLu   = StallIf | 6'(1 << StallIfId);
    localparam logic [5:0] StallMem  = StallLu | 6'(1 << StallIdEx) | 6'(1 << StallExMem)
                                     | 6'(1 << StallMemWb);

    localparam logic [31:0] ZeroWord = 32'h0000_0000;

    typedef enum logic {
        StRun   = 1'b0,
        StDrain = 1'b1
    } state_e;

    // x0 is hardwired to zero, so a load targeting it can never create a dependency.
    function automatic logic load_use_hit(
        input logic       isload,
        input logic [4:0] loadrd,
        input logic [4:0] rs1,
        input logic       rs1_read,
        input logic [4:0] rs2,
        input logic       rs2_read
    );
        return isload && (loadrd != 5'd0) &&
               ((rs1_read && (rs1 == loadrd)) || (rs2_read && (rs2 == loadrd)));
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Request/response bundle between the pipeline stages and the hazard controller.
// The master modport is the pipeline side; the slave modport is the controller.
interface hazard_ctrl_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned CNT_W  = 32
);

    logic              if_stall_req;
    logic              mem_stall_req;
    logic              ex_jump_req;
    logic [ADDR_W-1:0] ex_jump_target;
    logic              ex_isload;
    logic [4:0]        ex_loadrd;
    logic [4:0]        id_rs1;
    logic [4:0]        id_rs2;
    logic              id_rs1_read;
    logic              id_rs2_read;

    logic [5:0]        stall;
    logic              ifjump;
    logic              id_kill;
    logic              if_discard;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic [CNT_W-1:0]  cyc_cnt;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;
    logic [CNT_W-1:0]  lu_cnt;

    modport master (
        output if_stall_req, mem_stall_req, ex_jump_req, ex_jump_target,
        output ex_isload, ex_loadrd, id_rs1, id_rs2, id_rs1_read, id_rs2_read,
        input  stall, ifjump, id_kill, if_discard, redirect_valid, redirect_pc,
        input  cyc_cnt, stall_cnt, flush_cnt, lu_cnt
    );

    modport slave (
        input  if_stall_req, mem_stall_req, ex_jump_req, ex_jump_target,
        input  ex_isload, ex_loadrd, id_rs1, id_rs2, id_rs1_read, id_rs2_read,
        output stall, ifjump, id_kill, if_discard, redirect_valid, redirect_pc,
        output cyc_cnt, stall_cnt, flush_cnt, lu_cnt
    );

endinterface

// File: rtl/hazard_ctrl_perf_counters.sv
// Free-running performance counters for the hazard controller; all wrap modulo 2^CNT_W.
// Synchronous active-low reset clears every counter.
module hazard_ctrl_perf_counters #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_stall_pc,
    input  logic             i_ifjump,
    input  logic             i_lu_hit,
    output logic [CNT_W-1:0] o_cyc_cnt,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt,
    output logic [CNT_W-1:0] o_lu_cnt
);

    logic [CNT_W-1:0] r_cyc_cnt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic [CNT_W-1:0] r_lu_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cyc_cnt   <= '0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
            r_lu_cnt    <= '0;
        end else begin
            r_cyc_cnt <= r_cyc_cnt + CNT_W'(1);
            if (i_stall_pc) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (i_ifjump) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
            if (i_lu_hit) begin
                r_lu_cnt <= r_lu_cnt + CNT_W'(1);
            end
        end
    end

    assign o_cyc_cnt   = r_cyc_cnt;
    assign o_stall_cnt = r_stall_cnt;
    assign o_flush_cnt = r_flush_cnt;
    assign o_lu_cnt    = r_lu_cnt;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard and flush controller: resolves load-use, memory-busy, fetch-busy and
// branch-redirect events, holding a redirect across an in-flight fetch (DRAIN state).
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned CNT_W  = 32
) (
    input  logic          clk,
    input  logic          rst,
    hazard_ctrl_if.slave  bus
);

    state_e            r_state;
    state_e            w_state_d;
    logic [ADDR_W-1:0] r_tgt;
    logic [ADDR_W-1:0] w_tgt_d;

    logic              w_lu_hit;
    logic              w_lu_event;
    logic [5:0]        w_stall;
    logic              w_ifjump;
    logic              w_id_kill;
    logic              w_if_discard;
    logic              w_redirect_valid;
    logic [ADDR_W-1:0] w_redirect_pc;
    logic [CNT_W-1:0]  w_cyc_cnt;
    logic [CNT_W-1:0]  w_stall_cnt;
    logic [CNT_W-1:0]  w_flush_cnt;
    logic [CNT_W-1:0]  w_lu_cnt;

    assign w_lu_hit = load_use_hit(bus.ex_isload, bus.ex_loadrd, bus.id_rs1, bus.id_rs1_read,
                                   bus.id_rs2, bus.id_rs2_read);

    always_comb begin
        w_stall          = StallNone;
        w_ifjump         = 1'b0;
        w_id_kill        = 1'b0;
        w_if_discard     = 1'b0;
        w_redirect_valid = 1'b0;
        w_redirect_pc    = ADDR_W'(ZeroWord);
        w_lu_event       = 1'b0;
        w_state_d        = r_state;
        w_tgt_d          = r_tgt;
        if (!rst) begin
            w_state_d = StRun;
            w_tgt_d   = '0;
        end else begin
            unique case (r_state)
                StRun: begin
                    if (bus.mem_stall_req) begin
                        // EX keeps its jump request; it is re-evaluated once MEM frees up.
                        w_stall = StallMem;
                    end else if (bus.ex_jump_req && !bus.if_stall_req) begin
                        w_ifjump         = 1'b1;
                        w_redirect_valid = 1'b1;
                        w_redirect_pc    = bus.ex_jump_target;
                    end else if (bus.ex_jump_req) begin
                        w_ifjump     = 1'b1;
                        w_stall      = StallIf;
                        w_if_discard = 1'b1;
                        w_tgt_d      = bus.ex_jump_target;
                        w_state_d    = StDrain;
                    end else if (w_lu_hit) begin
                        w_stall    = StallLu;
                        w_id_kill  = 1'b1;
                        w_lu_event = 1'b1;
                    end else if (bus.if_stall_req) begin
                        w_stall = StallIf;
                    end
                end
                StDrain: begin
                    // Wrong-path fetch still outstanding; any EX jump here is a flushed bubble.
                    w_if_discard = 1'b1;
                    w_id_kill    = 1'b1;
                    w_stall      = bus.mem_stall_req ? StallMem : StallIf;
                    if (!bus.if_stall_req && !bus.mem_stall_req) begin
                        w_redirect_valid = 1'b1;
                        w_redirect_pc    = r_tgt;
                        w_state_d        = StRun;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= StRun;
            r_tgt   <= '0;
        end else begin
            r_state <= w_state_d;
            r_tgt   <= w_tgt_d;
        end
    end

    hazard_ctrl_perf_counters #(
        .CNT_W (CNT_W)
    ) u_perf_counters (
        .clk         (clk),
        .rst         (rst),
        .i_stall_pc  (w_stall[StallPc]),
        .i_ifjump    (w_ifjump),
        .i_lu_hit    (w_lu_event),
        .o_cyc_cnt   (w_cyc_cnt),
        .o_stall_cnt (w_stall_cnt),
        .o_flush_cnt (w_flush_cnt),
        .o_lu_cnt    (w_lu_cnt)
    );

    assign bus.stall          = w_stall;
    assign bus.ifjump         = w_ifjump;
    assign bus.id_kill        = w_id_kill;
    assign bus.if_discard     = w_if_discard;
    assign bus.redirect_valid = w_redirect_valid;
    assign bus.redirect_pc    = w_redirect_pc;
    assign bus.cyc_cnt        = w_cyc_cnt;
    assign bus.stall_cnt      = w_stall_cnt;
    assign bus.flush_cnt      = w_flush_cnt;
    assign bus.lu_cnt         = w_lu_cnt;

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and flush controller for the five-stage RISC-V core. It produces the `stall[5:0]` vector and the `ifjump` flush that the inter-stage registers (`if_id`, `id_ex`, `ex_mem`, `mem_wb`) consume. It also consumes the `isload`/`loadrd` pair published by the ID/EX register, which makes it the decision-making end of the stall/flush protocol. It resolves load-use, memory-busy, fetch-busy and branch-redirect events, holds a redirect across an in-flight fetch, and keeps performance counters.

## Interface
Parameters:
- `ADDR_W`, 32: PC/target width.
- `CNT_W`, 32: performance counter width.

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  reset, synchronous and active-low (0 = reset).
- `if_stall_req`  in  1  fetch waiting on memory.
- `mem_stall_req`  in  1  MEM-stage load/store waiting on memory.
- `ex_jump_req`  in  1  EX resolved a taken branch/jump.
- `ex_jump_target`  in  ADDR_W  redirect PC.
- `ex_isload`  in  1  instruction in EX is a load (`isload` from ID/EX).
- `ex_loadrd`  in  5  destination of that load (`loadrd`).
- `id_rs1`, `id_rs2`  in  5  source registers decoded in ID.
- `id_rs1_read`, `id_rs2_read`  in  1  source actually used.
- `stall`  out  6  [0]=pc, [1]=if_id, [2]=id_ex, [3]=ex_mem, [4]=mem_wb, [5]=wb; 1 = hold.
- `ifjump`  out  1  flush if_id and id_ex at next edge.
- `id_kill`  out  1  ID drives NOP into id_ex this cycle.
- `if_discard`  out  1  IF drops the returning (wrong-path) fetch.
- `redirect_valid`  out  1  load PC with `redirect_pc` at next edge.
- `redirect_pc`  out  ADDR_W  redirect address.
- `cyc_cnt`, `stall_cnt`, `flush_cnt`, `lu_cnt`  out  CNT_W  performance counters.

## Operation
- FSM states: RUN and DRAIN. Registers: `state`, `tgt_q`, and the four counters.
- Priority per cycle, with the first match winning. In RUN:
  1. `mem_stall_req`: stall=6'b011111. No flush or redirect; EX holds its jump request.
  2. `ex_jump_req && !if_stall_req`: ifjump=1, redirect_valid=1, redirect_pc=`ex_jump_target`, stall=0.
  3. `ex_jump_req && if_stall_req`: ifjump=1, stall=6'b000001, if_discard=1, latch target into `tgt_q`, go to DRAIN.
  4. Load-use: `ex_isload && ex_loadrd!=0 && ((id_rs1_read && id_rs1==ex_loadrd) || (id_rs2_read && id_rs2==ex_loadrd))` gives stall=6'b000011 and id_kill=1. This is a one-cycle bubble; the next cycle sees isload=0.
  5. `if_stall_req`: stall=6'b000001. IF itself supplies a NOP to if_id.
  6. Otherwise stall=0 and all other outputs 0.
- DRAIN behaviour:
  - Always if_discard=1 and id_kill=1.
  - stall=6'b011111 if `mem_stall_req`, else 6'b000001.
  - When `!if_stall_req && !mem_stall_req`: redirect_valid=1, redirect_pc=`tgt_q`, return to RUN.
  - `ex_jump_req` in DRAIN is ignored, because EX holds a flushed bubble.
- Outputs are combinational from inputs and state. Only `state`, `tgt_q` and the counters are registered.
- Counters wrap modulo 2^CNT_W:
  - cyc_cnt: +1 every non-reset cycle.
  - stall_cnt: +1 when stall[0]=1.
  - flush_cnt: +1 when ifjump=1.
  - lu_cnt: +1 on a RUN load-use match (rule 4).

## Timing
- Reset (rst=0 at posedge): state=RUN, tgt_q=0, all counters=0.
- While rst=0, outputs are forced low: stall=0, ifjump=0, id_kill=0, if_discard=0, redirect_valid=0, redirect_pc=0.
- Latencies:
  - Load-use and stall response: 0 cycles (same cycle as the request).
  - Redirect: 0 cycles in RUN. In DRAIN it is the first cycle with both memory requests low, and never earlier than one cycle after the jump.
  - Counters update at the edge following the event.
- Boundary and simultaneous-event rules:
  - Jump together with load-use: jump wins, and the dependent instruction is flushed.
  - mem_stall together with jump: stall wins, and the jump is re-evaluated next cycle.
  - `ex_loadrd==0` never stalls.
  - Reset in DRAIN returns to RUN with no redirect.

## Structure
- Shared `config.v` holds the stall bit indices, the STALL_* vector constants (NONE, IF=6'b000001, LU=6'b000011, MEM=6'b011111), the state encodings, and `ZeroWord`.
- A single sub-module `perf_counters` holds the four counters, their enables and reset.

## Test plan
- Load-use: EX lw x5 (isload=1, loadrd=5), ID add reading rs1=5 → stall=000011, id_kill=1 for one cycle, lu_cnt=1; the next cycle has stall=0.
- x0 load: isload=1, loadrd=0, id_rs1=0 → no stall, lu_cnt unchanged.
- Jump in RUN: ex_jump_req=1, target=0x100, if_stall_req=0 → ifjump=1, redirect_valid=1, redirect_pc=0x100 in the same cycle; flush_cnt=1.
- Jump under fetch-busy:
  - Stimulus: target=0x200 with if_stall_req=1 for 3 cycles.
  - Required: DRAIN with if_discard=1 and stall=000001, then redirect_pc=0x200 in the cycle if_stall_req falls.
- MEM stall over a jump: mem_stall_req=1 for 2 cycles with ex_jump_req=1 → stall=011111 and ifjump=0; ifjump=1 in the cycle after mem_stall_req drops. stall_cnt=2.
- Mid-DRAIN reset: rst=0 during DRAIN → state=RUN, all counters=0, no redirect issued afterwards.
